// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the button-press detector.
// Contents:
//   estado_t                - FSM state encodings, also used to label db_estado on the display
//   DEBOUNCE_CICLOS_PADRAO  - default stable-cycle count for accepting a press or a release
//   TIMEOUT_CICLOS_PADRAO   - default number of counted cycles before the play timeout
package detector_jogada_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,  // all buttons released and stable
        FILTRA = 3'd1,  // candidate pattern being debounced
        EMITE  = 3'd2,  // single-cycle jogada pulse
        SEGURA = 3'd3,  // waiting for release
        SOLTA  = 3'd4   // release being debounced
    } estado_t;

    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 1000;
    localparam int unsigned TIMEOUT_CICLOS_PADRAO  = 5000;

endpackage

// File: rtl/contador_timeout.sv
// Saturating cycle counter with synchronous clear and enable, and an expiry flag.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   i_zera    - synchronous clear of count and flag; wins over i_conta
//   i_conta   - count enable
//   o_expirou - high once CICLOS counted cycles have elapsed since the last clear
module contador_timeout #(
    parameter int unsigned CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_zera,
    input  logic i_conta,
    output logic o_expirou
);

    localparam int unsigned W = $clog2(CICLOS);
    localparam logic [W-1:0] ULTIMO = W'(CICLOS - 1);

    logic [W-1:0] r_cnt;
    logic         r_expirou;

    // Once the count reaches ULTIMO the flag sets on the next enabled edge and
    // the count stays put until cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_expirou <= 1'b0;
        end else if (i_zera) begin
            r_cnt     <= '0;
            r_expirou <= 1'b0;
        end else if (i_conta && !r_expirou) begin
            if (r_cnt == ULTIMO) begin
                r_expirou <= 1'b1;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_expirou = r_expirou;

endmodule

// File: rtl/detector_jogada.sv
// Player-button front end: synchronises and debounces the buttons, emits one
// jogada pulse per accepted single-button press, and runs the play timeout.
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-low reset
//   botoes       - raw button levels (asynchronous), 1 = pressed
//   zeraT        - synchronous clear of the timeout timer
//   contaT       - timeout timer enable
//   jogada       - one-cycle pulse per accepted press
//   jogada_valor - one-hot pattern of the last accepted press, held
//   timeout      - high once the timer has expired, until cleared
//   db_estado    - current FSM state encoding
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int unsigned N_BOTOES        = 4,
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int unsigned TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                zeraT,
    input  logic                contaT,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_valor,
    output logic                timeout,
    output logic [2:0]          db_estado
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [DW-1:0] DB_ULTIMO = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [DW-1:0] DB_UM     = DW'(1);

    logic [N_BOTOES-1:0] r_sync1, r_sync2;
    logic [N_BOTOES-1:0] w_s;
    estado_t             r_estado, w_prox_estado;
    logic [N_BOTOES-1:0] r_cand, w_prox_cand;
    logic [DW-1:0]       r_cnt, w_prox_cnt;
    logic [N_BOTOES-1:0] r_valor, w_prox_valor;
    logic                w_jogada;

    // Two-flop synchroniser; nothing downstream looks at the raw inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botoes;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_valor  <= '0;
        end else begin
            r_estado <= w_prox_estado;
            r_cand   <= w_prox_cand;
            r_cnt    <= w_prox_cnt;
            r_valor  <= w_prox_valor;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_prox_cand   = r_cand;
        w_prox_cnt    = r_cnt;
        w_prox_valor  = r_valor;
        w_jogada      = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_s != '0) begin
                    w_prox_cand   = w_s;
                    w_prox_cnt    = DB_UM;
                    w_prox_estado = FILTRA;
                end
            end
            FILTRA: begin
                if (w_s == '0) begin
                    w_prox_estado = OCIOSO;
                end else if (w_s != r_cand) begin
                    // Pattern changed mid-count: debounce the new one from scratch.
                    w_prox_cand = w_s;
                    w_prox_cnt  = DB_UM;
                end else if (r_cnt == DB_ULTIMO) begin
                    // Multi-button chords are dropped without a pulse.
                    if ($onehot(r_cand)) begin
                        w_prox_valor  = r_cand;
                        w_prox_estado = EMITE;
                    end else begin
                        w_prox_estado = SEGURA;
                    end
                end else begin
                    w_prox_cnt = r_cnt + DW'(1);
                end
            end
            EMITE: begin
                w_jogada      = 1'b1;
                w_prox_estado = SEGURA;
            end
            SEGURA: begin
                if (w_s == '0) begin
                    w_prox_cnt    = DB_UM;
                    w_prox_estado = SOLTA;
                end
            end
            SOLTA: begin
                if (w_s != '0) begin
                    w_prox_estado = SEGURA;
                end else if (r_cnt == DB_ULTIMO) begin
                    w_prox_estado = OCIOSO;
                end else begin
                    w_prox_cnt = r_cnt + DW'(1);
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // A play restarts the timer, and beats an expiry landing on the same edge.
    contador_timeout #(
        .CICLOS(TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_zera   (zeraT | w_jogada),
        .i_conta  (contaT),
        .o_expirou(timeout)
    );

    assign jogada       = w_jogada;
    assign jogada_valor = r_valor;
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed self-checking bench for detector_jogada with DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=10.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       zeraT;
    logic       contaT;
    logic       jogada;
    logic [3:0] jogada_valor;
    logic       timeout;
    logic [2:0] db_estado;

    int total = 0;
    int bad   = 0;

    detector_jogada #(
        .N_BOTOES       (4),
        .DEBOUNCE_CICLOS(4),
        .TIMEOUT_CICLOS (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .botoes      (botoes),
        .zeraT       (zeraT),
        .contaT      (contaT),
        .jogada      (jogada),
        .jogada_valor(jogada_valor),
        .timeout     (timeout),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        botoes = 4'b0000;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        botoes = 4'b0010;
        zeraT  = 1'b0;
        contaT = 1'b0;
        repeat (3) tick();
        total++; if (jogada !== 1'b0) begin bad++; $display("FAIL reset_jogada: got %b want 0", jogada); end
        total++; if (jogada_valor !== 4'b0000) begin bad++; $display("FAIL reset_valor: got %b want 0000", jogada_valor); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++; if (db_estado !== 3'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b1;
        // Button already held: sync1 at edge 1, s at 2, FILTRA at 3, EMITE at 6.
        for (int n = 1; n <= 10; n++) begin
            tick();
            total++;
            if (jogada !== (n == 6)) begin
                bad++; $display("FAIL reset_pulse edge %0d: got %b want %b", n, jogada, (n == 6));
            end
            if (n == 3) begin
                total++; if (db_estado !== 3'd1) begin bad++; $display("FAIL reset_filtra: got %0d want 1", db_estado); end
            end
            if (n == 6) begin
                total++; if (jogada_valor !== 4'b0010) begin bad++; $display("FAIL reset_pulse_valor: got %b want 0010", jogada_valor); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        // Still holding 4'b0010 in SEGURA; assert reset between edges.
        #2 reset = 1'b0;
        #1;
        total++; if (db_estado !== 3'd0) begin bad++; $display("FAIL mid_reset_estado: got %0d want 0", db_estado); end
        total++; if (jogada_valor !== 4'b0000) begin bad++; $display("FAIL mid_reset_valor: got %b want 0000", jogada_valor); end
        tick();
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (jogada === 1'b1) pulses++;
            total++;
            if (jogada !== (n == 6)) begin
                bad++; $display("FAIL mid_reset_pulse edge %0d: got %b want %b", n, jogada, (n == 6));
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL mid_reset_count: got %0d want 1", pulses); end
        settle();
    endtask

    task automatic test_clean_press();
        logic [2:0] seq[$];
        logic [2:0] exp_seq[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [2:0] got;
        int pulses = 0;
        seq.push_back(db_estado);
        botoes = 4'b0100;
        for (int n = 0; n < 30; n++) begin
            if (n == 20) botoes = 4'b0000;
            tick();
            if (jogada === 1'b1) begin
                pulses++;
                total++; if (jogada_valor !== 4'b0100) begin bad++; $display("FAIL clean_valor: got %b want 0100", jogada_valor); end
            end
            if (db_estado !== seq[$]) seq.push_back(db_estado);
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL clean_count: got %0d want 1", pulses); end
        total++; if (seq.size() != 6) begin bad++; $display("FAIL clean_walk_len: got %0d want 6", seq.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < seq.size()) ? seq[i] : 3'd7;
            total++;
            if (got !== exp_seq[i]) begin bad++; $display("FAIL clean_walk[%0d]: got %0d want %0d", i, got, exp_seq[i]); end
        end
        total++; if (jogada_valor !== 4'b0100) begin bad++; $display("FAIL clean_hold_valor: got %b want 0100", jogada_valor); end
        settle();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 6; i++) begin
            botoes = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            total++; if (jogada !== 1'b0) begin bad++; $display("FAIL bounce_quiet %0d: got %b want 0", i, jogada); end
        end
        botoes = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            tick();
            total++;
            if (jogada !== (n == 6)) begin
                bad++; $display("FAIL bounce_pulse edge %0d: got %b want %b", n, jogada, (n == 6));
            end
            if (n == 6) begin
                total++; if (jogada_valor !== 4'b0001) begin bad++; $display("FAIL bounce_valor: got %b want 0001", jogada_valor); end
            end
        end
        settle();
    endtask

    task automatic test_two_buttons();
        int pulses = 0;
        botoes = 4'b0011;
        repeat (10) begin
            tick();
            if (jogada === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL chord_pulses: got %0d want 0", pulses); end
        total++; if (db_estado !== 3'd3) begin bad++; $display("FAIL chord_estado: got %0d want 3", db_estado); end
        total++; if (jogada_valor !== 4'b0001) begin bad++; $display("FAIL chord_valor: got %b want 0001", jogada_valor); end
        settle();
    endtask

    task automatic test_timeout();
        zeraT  = 1'b1;
        contaT = 1'b1;
        tick();
        zeraT = 1'b0;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_cleared: got %b want 0", timeout); end
        for (int n = 1; n <= 13; n++) begin
            tick();
            total++;
            if (timeout !== (n >= 10)) begin
                bad++; $display("FAIL to_expire edge %0d: got %b want %b", n, timeout, (n >= 10));
            end
        end
        zeraT = 1'b1;
        tick();
        zeraT = 1'b0;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_zera: got %b want 0", timeout); end
        // Count 5, pause 5 (value held), then 5 more reaches expiry.
        repeat (5) tick();
        contaT = 1'b0;
        repeat (5) tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_hold: got %b want 0", timeout); end
        contaT = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            total++;
            if (timeout !== (n >= 5)) begin
                bad++; $display("FAIL to_resume edge %0d: got %b want %b", n, timeout, (n >= 5));
            end
        end
        contaT = 1'b0;
        zeraT  = 1'b1;
        tick();
        zeraT = 1'b0;
    endtask

    task automatic test_jogada_expiry();
        // Clear at edge E0; press set after E0+3 pulses in the cycle after E0+9,
        // exactly when the timer sits at 9.
        zeraT  = 1'b1;
        contaT = 1'b1;
        tick();
        zeraT = 1'b0;
        repeat (3) tick();
        botoes = 4'b1000;
        for (int n = 4; n <= 21; n++) begin
            tick();
            total++;
            if (jogada !== (n == 9)) begin
                bad++; $display("FAIL exp_pulse edge %0d: got %b want %b", n, jogada, (n == 9));
            end
            total++;
            if (timeout !== (n >= 20)) begin
                bad++; $display("FAIL exp_timeout edge %0d: got %b want %b", n, timeout, (n >= 20));
            end
        end
        contaT = 1'b0;
        zeraT  = 1'b1;
        tick();
        zeraT = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_clean_press();
        test_bounce();
        test_two_buttons();
        test_timeout();
        test_jogada_expiry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
